// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mstatus/mie/mip CSR state plus one prioritised,
// registered trap request to the pipeline through a req/ack handshake.
module irq_ctrl (
  input  logic        clk,
  input  logic        resetb,
  input  logic        irq_mtimecmp,
  input  logic        irq_ext,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  output logic        trap_req,
  output logic [31:0] trap_cause,
  input  logic        trap_ack,
  input  logic        mret
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_mst_mie;
  logic        r_mst_mpie;
  logic        r_mie_msie;
  logic        r_mie_mtie;
  logic        r_mie_meie;
  logic        r_mip_msip;
  logic [1:0]  r_meip_sync;
  logic [31:0] r_trap_cause;

  logic        w_sel_mstatus;
  logic        w_sel_mie;
  logic        w_sel_mip;
  logic        w_wr_mstatus;
  logic        w_wr_mie;
  logic        w_wr_mip;
  logic        w_meip;
  logic        w_mtip;
  logic        w_pend_mei;
  logic        w_pend_msi;
  logic        w_pend_mti;
  logic        w_pend_any;
  logic        w_ack;
  logic        w_take;
  logic [31:0] w_cause;
  logic        w_unused_wdata;

  assign w_sel_mstatus = (csr_addr == ADDR_MSTATUS);
  assign w_sel_mie     = (csr_addr == ADDR_MIE);
  assign w_sel_mip     = (csr_addr == ADDR_MIP);
  assign w_wr_mstatus  = csr_we & w_sel_mstatus;
  assign w_wr_mie      = csr_we & w_sel_mie;
  assign w_wr_mip      = csr_we & w_sel_mip;

  // Only bits 3/7/11 of the write data are ever stored.
  assign w_unused_wdata = ^{csr_wdata[31:12], csr_wdata[10:8], csr_wdata[6:4], csr_wdata[2:0]};

  assign w_mtip = irq_mtimecmp;
  assign w_meip = r_meip_sync[1];

  assign w_pend_mei = w_meip     & r_mie_meie;
  assign w_pend_msi = r_mip_msip & r_mie_msie;
  assign w_pend_mti = w_mtip     & r_mie_mtie;
  assign w_pend_any = w_pend_mei | w_pend_msi | w_pend_mti;

  // An ack only counts while a request is outstanding.
  assign w_ack  = trap_ack & (r_state == S_REQ);
  assign w_take = (r_state == S_IDLE) & (w_state_nxt == S_REQ);

  always_comb begin
    w_cause = CAUSE_MTI;
    if (w_pend_mei)      w_cause = CAUSE_MEI;
    else if (w_pend_msi) w_cause = CAUSE_MSI;
  end

  // Handshake FSM: state register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Handshake FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_mst_mie && w_pend_any) w_state_nxt = S_REQ;
      S_REQ:   if (trap_ack)                w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake FSM: outputs
  always_comb begin
    trap_req   = (r_state == S_REQ);
    trap_cause = r_trap_cause;
  end

  // Cause is captured only on the request edge and then frozen until the next one.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)     r_trap_cause <= '0;
    else if (w_take) r_trap_cause <= w_cause;
  end

  // mstatus: trap entry beats mret, which beats a CSR write.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_mst_mie  <= 1'b0;
      r_mst_mpie <= 1'b0;
    end else if (w_ack) begin
      r_mst_mpie <= r_mst_mie;
      r_mst_mie  <= 1'b0;
    end else if (mret) begin
      r_mst_mie  <= r_mst_mpie;
      r_mst_mpie <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mst_mie  <= csr_wdata[3];
      r_mst_mpie <= csr_wdata[7];
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_mie_msie <= 1'b0;
      r_mie_mtie <= 1'b0;
      r_mie_meie <= 1'b0;
    end else if (w_wr_mie) begin
      r_mie_msie <= csr_wdata[3];
      r_mie_mtie <= csr_wdata[7];
      r_mie_meie <= csr_wdata[11];
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)       r_mip_msip <= 1'b0;
    else if (w_wr_mip) r_mip_msip <= csr_wdata[3];
  end

  // irq_ext is asynchronous to clk; two flops before anything looks at it.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_meip_sync <= 2'b00;
    else         r_meip_sync <= {r_meip_sync[0], irq_ext};
  end

  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_hit       = 1'b1;
        csr_rdata[12:11] = 2'b11;
        csr_rdata[7]  = r_mst_mpie;
        csr_rdata[3]  = r_mst_mie;
      end
      ADDR_MIE: begin
        csr_hit       = 1'b1;
        csr_rdata[11] = r_mie_meie;
        csr_rdata[7]  = r_mie_mtie;
        csr_rdata[3]  = r_mie_msie;
      end
      ADDR_MIP: begin
        csr_hit       = 1'b1;
        csr_rdata[11] = w_meip;
        csr_rdata[7]  = w_mtip;
        csr_rdata[3]  = r_mip_msip;
      end
      default: begin
        csr_rdata = '0;
        csr_hit   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: cycle-by-cycle vector table, then directed sequences for
// priority/freeze, simultaneous events and asynchronous reset mid-handshake.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        resetb;
  logic        irq_mtimecmp;
  logic        irq_ext;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic        trap_ack;
  logic        mret;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk          (clk),
    .resetb       (resetb),
    .irq_mtimecmp (irq_mtimecmp),
    .irq_ext      (irq_ext),
    .csr_addr     (csr_addr),
    .csr_we       (csr_we),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .csr_hit      (csr_hit),
    .trap_req     (trap_req),
    .trap_cause   (trap_cause),
    .trap_ack     (trap_ack),
    .mret         (mret)
  );

  // One record = inputs held for one cycle plus the outputs expected before that edge.
  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        tmr;
    logic        ext;
    logic        ack;
    logic        ret;
    logic [31:0] exp_rdata;
    logic        exp_hit;
    logic        exp_req;
    logic [31:0] exp_cause;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [11:0] a, logic we, logic [31:0] wd, logic t, logic e,
                              logic ak, logic rt, logic [31:0] rd, logic h, logic rq,
                              logic [31:0] c);
    vec_t v;
    v.addr = a; v.we = we; v.wdata = wd; v.tmr = t; v.ext = e; v.ack = ak; v.ret = rt;
    v.exp_rdata = rd; v.exp_hit = h; v.exp_req = rq; v.exp_cause = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    csr_we = 1'b0; csr_wdata = '0; trap_ack = 1'b0; mret = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a; csr_we = 1'b1; csr_wdata = d;
    step();
    csr_we = 1'b0;
  endtask

  task automatic csr_rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  initial begin
    resetb = 1'b0; irq_mtimecmp = 1'b0; irq_ext = 1'b0; csr_addr = '0;
    idle_inputs();

    //              addr    we wdata         t  e  ak rt rdata         hit req cause
    vecs.push_back(mk(12'h300,0,32'h0,        0,0,0,0, 32'h0000_1800,1, 0, 32'h0));
    vecs.push_back(mk(12'h304,0,32'h0,        0,0,0,0, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(12'h344,0,32'h0,        0,0,0,0, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(12'h305,0,32'h0,        0,0,0,0, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(12'h305,1,32'hFFFF_FFFF,0,0,0,0, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(12'h304,1,32'hFFFF_FFFF,0,0,0,0, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(12'h304,1,32'h80,       0,0,0,0, 32'h888,      1, 0, 32'h0));
    vecs.push_back(mk(12'h300,1,32'hFFFF_FFFF,0,0,0,0, 32'h0000_1800,1, 0, 32'h0));
    vecs.push_back(mk(12'h300,1,32'h8,        0,0,0,0, 32'h0000_1888,1, 0, 32'h0));
    vecs.push_back(mk(12'h300,0,32'h0,        1,0,0,0, 32'h0000_1808,1, 0, 32'h0));
    vecs.push_back(mk(12'h344,0,32'h0,        0,0,0,0, 32'h0,        1, 1, 32'h8000_0007));
    vecs.push_back(mk(12'h344,0,32'h0,        1,0,1,0, 32'h80,       1, 1, 32'h8000_0007));
    vecs.push_back(mk(12'h300,0,32'h0,        1,0,0,0, 32'h0000_1880,1, 0, 32'h8000_0007));
    vecs.push_back(mk(12'h300,0,32'h0,        1,0,0,1, 32'h0000_1880,1, 0, 32'h8000_0007));
    vecs.push_back(mk(12'h300,0,32'h0,        0,0,1,0, 32'h0000_1888,1, 0, 32'h8000_0007));
    vecs.push_back(mk(12'h344,1,32'h8,        0,0,0,0, 32'h0,        1, 0, 32'h8000_0007));
    vecs.push_back(mk(12'h344,0,32'h0,        0,0,0,0, 32'h8,        1, 0, 32'h8000_0007));
    vecs.push_back(mk(12'h304,1,32'h8,        0,0,0,0, 32'h80,       1, 0, 32'h8000_0007));
    vecs.push_back(mk(12'h304,0,32'h0,        0,0,0,0, 32'h8,        1, 0, 32'h8000_0007));
    vecs.push_back(mk(12'h344,1,32'h0,        0,0,1,0, 32'h8,        1, 1, 32'h8000_0003));
    vecs.push_back(mk(12'h344,0,32'h0,        0,0,0,0, 32'h0,        1, 0, 32'h8000_0003));
    vecs.push_back(mk(12'h300,0,32'h0,        0,0,0,0, 32'h0000_1880,1, 0, 32'h8000_0003));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_trap_req", {31'b0, trap_req}, 32'h0);
    chk("reset_trap_cause", trap_cause, 32'h0);
    resetb = 1'b1;
    #1;

    foreach (vecs[i]) begin
      csr_addr = vecs[i].addr; csr_we = vecs[i].we; csr_wdata = vecs[i].wdata;
      irq_mtimecmp = vecs[i].tmr; irq_ext = vecs[i].ext;
      trap_ack = vecs[i].ack; mret = vecs[i].ret;
      #1;
      chk($sformatf("v%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_hit", i), {31'b0, csr_hit}, {31'b0, vecs[i].exp_hit});
      chk($sformatf("v%0d_req", i), {31'b0, trap_req}, {31'b0, vecs[i].exp_req});
      chk($sformatf("v%0d_cause", i), trap_cause, vecs[i].exp_cause);
      step();
    end
    idle_inputs();
    irq_mtimecmp = 1'b0; irq_ext = 1'b0;

    // Priority and freeze: MTI wins the race because MEIP trails by the synchroniser.
    csr_wr(12'h304, 32'h888);
    csr_wr(12'h300, 32'h8);
    irq_mtimecmp = 1'b1; irq_ext = 1'b1;
    step();
    chk("prio_req", {31'b0, trap_req}, 32'h1);
    chk("prio_first_cause", trap_cause, 32'h8000_0007);
    step(); step();
    csr_rd_chk("prio_mip_meip", 12'h344, 32'h880);
    chk("prio_frozen_cause", trap_cause, 32'h8000_0007);
    csr_wr(12'h304, 32'h0);
    chk("prio_hold_mie0", {31'b0, trap_req}, 32'h1);
    csr_wr(12'h304, 32'h888);
    trap_ack = 1'b1; step(); trap_ack = 1'b0;
    chk("prio_ack_req", {31'b0, trap_req}, 32'h0);
    mret = 1'b1; step(); mret = 1'b0;
    chk("prio_mret_req0", {31'b0, trap_req}, 32'h0);
    step();
    chk("prio_rereq", {31'b0, trap_req}, 32'h1);
    chk("prio_mei_cause", trap_cause, 32'h8000_000B);

    // Simultaneous events; sources drained first so nothing re-requests afterwards.
    irq_mtimecmp = 1'b0; irq_ext = 1'b0;
    step(); step(); step();
    chk("coll_req_held", {31'b0, trap_req}, 32'h1);
    csr_addr = 12'h300; csr_we = 1'b1; csr_wdata = 32'h8; trap_ack = 1'b1;
    step();
    idle_inputs();
    csr_rd_chk("coll_ack_vs_wr", 12'h300, 32'h0000_1880);
    chk("coll_ack_req", {31'b0, trap_req}, 32'h0);
    csr_addr = 12'h300; csr_we = 1'b1; csr_wdata = 32'h0; mret = 1'b1;
    step();
    idle_inputs();
    csr_rd_chk("coll_mret_vs_wr", 12'h300, 32'h0000_1888);
    step();
    chk("coll_no_req", {31'b0, trap_req}, 32'h0);

    // Asynchronous reset between request and ack.
    csr_wr(12'h344, 32'h8);
    step();
    chk("arst_pre_req", {31'b0, trap_req}, 32'h1);
    chk("arst_pre_cause", trap_cause, 32'h8000_0003);
    #2;
    resetb = 1'b0;
    #1;
    chk("arst_req", {31'b0, trap_req}, 32'h0);
    chk("arst_cause", trap_cause, 32'h0);
    csr_rd_chk("arst_mstatus", 12'h300, 32'h0000_1800);
    csr_rd_chk("arst_mie", 12'h304, 32'h0);
    csr_rd_chk("arst_mip", 12'h344, 32'h0);
    step();
    resetb = 1'b1;
    step(); step();
    chk("arst_after_req", {31'b0, trap_req}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Machine-mode interrupt controller for the rv32i pipeline. It consumes the level-sensitive `irq_mtimecmp` from the IO-space system timer, an asynchronous external interrupt pin, and a software interrupt bit. It holds the `mstatus`/`mie`/`mip` CSR state and presents one prioritised, registered trap request to the pipeline's trap logic through a req/ack handshake. It sits between the timer (and other IRQ sources) and the pipeline's CSR/exception stage.

## Interface
Parameters
- none (CSR addresses fixed: mstatus 0x300, mie 0x304, mip 0x344)

Ports
- clk  in  1  system clock, all state on rising edge
- resetb  in  1  asynchronous, active-low reset
- irq_mtimecmp  in  1  timer interrupt level from the system timer (synchronous to clk)
- irq_ext  in  1  external interrupt level, asynchronous to clk
- csr_addr  in  12  CSR address from the pipeline CSR stage
- csr_we  in  1  CSR write strobe (full-word write of csr_wdata)
- csr_wdata  in  32  CSR write data
- csr_rdata  out  32  combinational read data for csr_addr
- csr_hit  out  1  combinational; 1 when csr_addr is 0x300, 0x304 or 0x344
- trap_req  out  1  registered interrupt request to pipeline
- trap_cause  out  32  mcause value; valid and frozen while trap_req=1
- trap_ack  in  1  pipeline takes the trap this cycle
- mret  in  1  pipeline retires MRET this cycle

## Operation
- mstatus
  - MIE at bit 3 (rw); MPIE at bit 7 (rw).
  - MPP at bits 12:11 reads 2'b11, writes ignored.
  - All other bits read 0.
- mie
  - MSIE at bit 3, MTIE at bit 7, MEIE at bit 11; all rw.
  - Other bits read 0, writes ignored.
- mip
  - MSIP at bit 3: rw, a flop.
  - MTIP at bit 7: read-only, equals irq_mtimecmp directly, no flop.
  - MEIP at bit 11: read-only, equals the output of a 2-flop synchroniser on irq_ext.
- Unmapped csr_addr: csr_rdata=0, csr_hit=0, writes ignored.
- Pending: pend = mip & mie (bits 3/7/11).
- Request rule: when trap_req=0 and mstatus.MIE=1 and pend≠0, on the next edge set trap_req=1 and latch trap_cause.
- Cause priority, highest first:
  - MEI: 0x8000000B
  - MSI: 0x80000003
  - MTI: 0x80000007
- While trap_req=1:
  - trap_req and trap_cause hold regardless of pend, mie or MIE changes, until trap_ack.
  - Sources are level-based. Software clears the source (mtimecmp rewrite, MSIP=0, device) inside the handler.
- trap_ack=1 with trap_req=1, on the next edge:
  - trap_req←0.
  - MPIE←MIE, MIE←0.
  - trap_cause holds its value.
- trap_ack while trap_req=0: ignored.
- mret=1, on the next edge: MIE←MPIE, MPIE←1.
- Simultaneous events:
  - trap_ack + csr_we to mstatus: trap_ack update wins for MIE/MPIE; the write is dropped.
  - trap_ack + csr_we to mie/mip: both take effect.
  - mret + csr_we to mstatus: mret wins.
  - trap_ack + mret together: illegal from the pipeline; trap_ack wins, mret is ignored.
- Re-request: once trap_req drops, the next request needs MIE=1 again (i.e. after mret or a software set).

## Timing
- Reset (asynchronous, any cycle, including mid-handshake): every bit below clears to 0 immediately.
  - trap_req, trap_cause
  - MIE, MPIE
  - mie (all bits), MSIP
  - both synchroniser flops
- csr_rdata and csr_hit are valid in the same cycle as csr_addr.
- csr_we takes effect at the edge; reads in the following cycle see the new value.
- MTI latency: irq_mtimecmp rises before edge N with MIE=MTIE=1 → trap_req=1 after edge N.
- MEI latency: irq_ext rises → MEIP=1 after 2 edges → trap_req=1 after the 3rd edge.
- MSI latency: csr_we setting MSIP at edge N → trap_req=1 after edge N+1.
- After an ack at edge N, trap_req is 0 from N and stays low for at least 1 cycle. MIE=0 blocks a new request until software or mret re-enables it.
- A write of MIE=1 at edge N with pend≠0 → trap_req=1 after edge N+1.

## Test plan
- Reset defaults: deassert resetb, read 0x300/0x304/0x344 → 0x00001800 / 0 / 0; trap_req=0.
- MTI path:
  - Stimulus: write mie=0x80, mstatus=0x8, then pulse irq_mtimecmp high.
  - trap_req=1 one edge later, trap_cause=0x80000007.
  - Ack → trap_req=0; mstatus reads 0x1880.
  - mret → mstatus reads 0x1888.
- Priority and freeze:
  - Stimulus: enable all three sources, MIE=1, raise irq_ext and irq_mtimecmp together.
  - The MTI request latches first (cause 0x80000007) because MEIP lags by the synchroniser.
  - The cause stays 0x80000007 after MEIP rises, until ack.
  - After mret, trap_cause=0x8000000B.
- Masking: set MSIP with MSIE=0 → mip=0x8, trap_req stays 0; set MSIE → trap_req=1 after 2 edges, cause 0x80000003.
- Collisions:
  - trap_ack in the same cycle as csr_we mstatus=0x8 → MIE=0, MPIE=1.
  - mret with csr_we mstatus=0 → MIE=MPIE(old), MPIE=1.
- Async reset mid-handshake: assert resetb low between trap_req=1 and trap_ack → trap_req=0 and trap_cause=0 immediately, without waiting for a clock edge.
